// File: rtl/full_adder_pkg.sv
// Shared constants and reference arithmetic for the full_adder ripple-carry adder.
package full_adder_pkg;

  localparam int DefaultWidth = 1;
  localparam int MaxRefW = 32;

  // Returns {carry, sum} with the carry landing on bit w; bits above w are zero.
  function automatic logic [MaxRefW:0] fa_ref(
    input logic [MaxRefW-1:0] a,
    input logic [MaxRefW-1:0] b,
    input logic               cin,
    input int unsigned        w
  );
    logic [MaxRefW:0] m;
    m = ({{MaxRefW{1'b0}}, 1'b1} << w) - 1'b1;
    return ({1'b0, a} & m) + ({1'b0, b} & m)
         + {{MaxRefW{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder cell: sum and majority carry.
module full_add_cell
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of width_p cells with a registered copy of its result.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int width_p = DefaultWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               carry_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o,
  output logic [width_p-1:0] sum_r_o,
  output logic               carry_r_o
);

  logic [width_p:0]   c;
  logic [width_p-1:0] sum_r_d, sum_r_q;
  logic               carry_r_d, carry_r_q;

  assign c[0] = carry_i;

  for (genvar k = 0; k < width_p; k++) begin : g_cell
    full_add_cell u_cell (
      .a_i (a_i[k]),
      .b_i (b_i[k]),
      .c_i (c[k]),
      .s_o (sum_o[k]),
      .c_o (c[k+1])
    );
  end

  assign carry_o = c[width_p];

  assign sum_r_d   = sum_o;
  assign carry_r_d = carry_o;

  // Reset clears only the pipeline copy; the adder stays live.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_r_q   <= '0;
      carry_r_q <= 1'b0;
    end else begin
      sum_r_q   <= sum_r_d;
      carry_r_q <= carry_r_d;
    end
  end

  assign sum_r_o   = sum_r_q;
  assign carry_r_o = carry_r_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at widths 1 and 4.
module tb_full_adder;

  localparam int K_COMB1 = 0;
  localparam int K_REG1  = 1;
  localparam int K_COMB4 = 2;
  localparam int K_REG4  = 3;

  typedef struct {
    int         kind;
    logic [4:0] exp;
    string      name;
  } sb_t;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic       s1, co1, sr1, cr1;
  logic [3:0] s4, sr4;
  logic       co4, cr4;

  int  checks = 0;
  int  errors = 0;
  sb_t q[$];
  event mon_ev;

  full_adder #(.width_p(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_i(a1), .b_i(b1), .carry_i(c1),
    .sum_o(s1), .carry_o(co1),
    .sum_r_o(sr1), .carry_r_o(cr1)
  );

  full_adder #(.width_p(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_i(a4), .b_i(b4), .carry_i(c4),
    .sum_o(s4), .carry_o(co4),
    .sum_r_o(sr4), .carry_r_o(cr4)
  );

  always #5 clk = clk_en ? ~clk : clk;

  // Reference: plain integer addition, carry is whatever spills past width.
  function automatic logic [4:0] ref_add(int a, int b, int c, int w);
    int t;
    logic [4:0] r;
    t = a + b + c;
    r = 5'(t);
    if (w == 1) r = r & 5'b00011;
    return r;
  endfunction

  task automatic expect_now(int kind, logic [4:0] exp, string name);
    sb_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    -> mon_ev;
    #1;
  endtask

  // Monitor: samples the output group named by the oldest expectation.
  initial begin
    sb_t e;
    logic [4:0] got;
    forever begin
      @(mon_ev);
      if (q.size() == 0) begin
        errors++;
        $display("FAIL monitor: event with empty scoreboard");
      end else begin
        e = q.pop_front();
        got = '0;
        unique case (e.kind)
          K_COMB1: got = {3'b000, co1, s1};
          K_REG1:  got = {3'b000, cr1, sr1};
          K_COMB4: got = {co4, s4};
          default: got = {cr4, sr4};
        endcase
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
        end
      end
    end
  end

  initial begin
    logic [4:0] r;
    #1 rst_n = 1'b0;
    #2;
    // Reset state, no clock running
    expect_now(K_REG1, 5'b0, "reset_reg1");
    expect_now(K_REG4, 5'b0, "reset_reg4");

    // Width 1 exhaustive under reset with the clock stopped
    for (int i = 0; i < 8; i++) begin
      a1 = i[0]; b1 = i[1]; c1 = i[2];
      #10;
      expect_now(K_COMB1, ref_add(i & 1, (i >> 1) & 1, (i >> 2) & 1, 1),
                 $sformatf("comb1_%0d", i));
    end
    a1 = 1; b1 = 1; c1 = 0;
    #10;
    expect_now(K_COMB1, 5'b00010, "comb1_rst_110");
    expect_now(K_REG1, 5'b0, "reg1_held_in_reset");

    // Start clock; release reset with 1+1+1 applied
    clk_en = 1'b1;
    a1 = 1; b1 = 1; c1 = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_now(K_REG1, 5'b00011, "reg1_first_capture");

    // Registered latency: prior value holds until the edge
    @(negedge clk);
    a1 = 1; b1 = 0; c1 = 1;
    #1;
    expect_now(K_REG1, 5'b00011, "reg1_prior_hold");
    @(posedge clk); #1;
    expect_now(K_REG1, 5'b00010, "reg1_latency");

    // Async reset between edges
    @(negedge clk);
    a1 = 1; b1 = 0; c1 = 0;
    @(posedge clk); #1;
    expect_now(K_REG1, 5'b00001, "reg1_before_rst");
    #1 rst_n = 1'b0;
    #1;
    expect_now(K_REG1, 5'b0, "reg1_async_clear");
    expect_now(K_COMB1, 5'b00001, "comb1_during_rst");
    @(posedge clk); #1;
    expect_now(K_REG1, 5'b0, "reg1_hold_in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 0; b1 = 1; c1 = 1;
    @(posedge clk); #1;
    expect_now(K_REG1, 5'b00010, "reg1_after_release");

    // Width 4 directed ripple and boundary cases
    a4 = 4'hF; b4 = 4'h0; c4 = 1; #10;
    expect_now(K_COMB4, 5'h10, "comb4_F_0_1");
    a4 = 4'h7; b4 = 4'h8; c4 = 0; #10;
    expect_now(K_COMB4, 5'h0F, "comb4_7_8_0");
    a4 = 4'hF; b4 = 4'hF; c4 = 1; #10;
    expect_now(K_COMB4, 5'h1F, "comb4_all_ones");
    a4 = 4'h0; b4 = 4'h0; c4 = 0; #10;
    expect_now(K_COMB4, 5'h00, "comb4_all_zero");

    // Width 4 exhaustive 512 combos
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; c4 = i[8];
      #2;
      expect_now(K_COMB4, ref_add(i & 15, (i >> 4) & 15, (i >> 8) & 1, 4),
                 $sformatf("comb4_%0d", i));
    end

    // Width 4 registered path with random operands
    for (int n = 0; n < 40; n++) begin
      int ra, rb, rc;
      @(negedge clk);
      ra = int'($urandom_range(15));
      rb = int'($urandom_range(15));
      rc = int'($urandom_range(1));
      a4 = 4'(ra); b4 = 4'(rb); c4 = rc[0];
      r = ref_add(ra, rb, rc, 4);
      @(posedge clk); #1;
      expect_now(K_REG4, r, $sformatf("reg4_rand_%0d", n));
    end

    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
